// File: rtl/voice_scheduler.sv
// voice_scheduler: time-slot sweep controller and voice allocator for the
// shared envelope datapath. Each sample_tick sweeps a one-hot slot select
// over all voices. Note events update the voice tables only between sweeps,
// so every slot of a sweep sees the same table state.
module voice_scheduler #(
  parameter int NUM_CHAN = 16,
  parameter int NUM_BITS = 32,
  parameter int KEY_BITS = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_tick,
  input  logic                ev_valid,
  output logic                ev_ready,
  input  logic                ev_on,
  input  logic [KEY_BITS-1:0] ev_key,
  input  logic [NUM_BITS-1:0] ev_velocity,
  output logic [NUM_CHAN-1:0] curr_note,
  output logic [NUM_CHAN-1:0] note_enable,
  output logic [NUM_CHAN-1:0] acc_en,
  output logic [NUM_BITS-1:0] velocity,
  output logic                sweep_done,
  output logic                tick_overrun
);

  localparam int SW = $clog2(NUM_CHAN);

  typedef enum logic [1:0] {IDLE, SWEEP, EVENT} state_t;

  state_t                             state_q, state_d;
  logic [SW-1:0]                      slot_q, slot_d;
  logic [SW-1:0]                      steal_q, steal_d;
  logic                               tick_pend_q, tick_pend_d;
  logic                               overrun_q, overrun_d;
  logic [NUM_CHAN-1:0][KEY_BITS-1:0]  key_q, key_d;
  logic [NUM_CHAN-1:0][NUM_BITS-1:0]  vel_q, vel_d;
  logic [NUM_CHAN-1:0]                nen_q, nen_d;
  logic                               ev_on_q, ev_on_d;
  logic [KEY_BITS-1:0]                ev_key_q, ev_key_d;
  logic [NUM_BITS-1:0]                ev_vel_q, ev_vel_d;
  logic [NUM_CHAN-1:0]                cn_q, cn_d;
  logic [NUM_BITS-1:0]                velo_q, velo_d;
  logic                               done_q, done_d;

  logic                               match_hit, free_hit;
  logic [SW-1:0]                      match_idx, free_idx, slot_nxt;
  logic [NUM_CHAN-1:0]                off_mask;

  // Ticks win over events; reset holds the event port closed.
  assign ev_ready = !rst && (state_q == IDLE) && !sample_tick && !tick_pend_q;

  assign curr_note    = cn_q;
  assign acc_en       = cn_q;
  assign velocity     = velo_q;
  assign note_enable  = nen_q;
  assign sweep_done   = done_q;
  assign tick_overrun = overrun_q;
  assign slot_nxt     = slot_q + SW'(1);

  // Voice lookup for the captured event; descending scan leaves the lowest index.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    off_mask  = '0;
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      if (nen_q[i] && (key_q[i] == ev_key_q)) begin
        match_hit   = 1'b1;
        match_idx   = SW'(i);
        off_mask[i] = 1'b1;
      end
      if (!nen_q[i]) begin
        free_hit = 1'b1;
        free_idx = SW'(i);
      end
    end
  end

  // Next-state, sweep outputs and table updates.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    steal_d     = steal_q;
    tick_pend_d = tick_pend_q;
    overrun_d   = overrun_q;
    key_d       = key_q;
    vel_d       = vel_q;
    nen_d       = nen_q;
    ev_on_d     = ev_on_q;
    ev_key_d    = ev_key_q;
    ev_vel_d    = ev_vel_q;
    cn_d        = '0;
    velo_d      = '0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (sample_tick || tick_pend_q) begin
          state_d     = SWEEP;
          slot_d      = '0;
          tick_pend_d = 1'b0;
          cn_d[0]     = 1'b1;
          velo_d      = vel_q[0];
        end else if (ev_valid && ev_ready) begin
          ev_on_d  = ev_on;
          ev_key_d = ev_key;
          ev_vel_d = ev_velocity;
          state_d  = EVENT;
        end
      end
      SWEEP: begin
        if (slot_q == SW'(NUM_CHAN - 1)) begin
          state_d = IDLE;
          slot_d  = '0;
          done_d  = 1'b1;
        end else begin
          slot_d         = slot_nxt;
          cn_d[slot_nxt] = 1'b1;
          velo_d         = vel_q[slot_nxt];
        end
      end
      EVENT: begin
        state_d = IDLE;
        if (ev_on_q) begin
          if (match_hit) begin
            vel_d[match_idx] = ev_vel_q;
          end else if (free_hit) begin
            key_d[free_idx] = ev_key_q;
            vel_d[free_idx] = ev_vel_q;
            nen_d[free_idx] = 1'b1;
          end else begin
            key_d[steal_q] = ev_key_q;
            vel_d[steal_q] = ev_vel_q;
            steal_d        = steal_q + SW'(1);
          end
        end else begin
          nen_d = nen_q & ~off_mask;
        end
      end
      default: state_d = IDLE;
    endcase

    // Busy ticks queue once; a second one while queued is lost.
    if ((state_q != IDLE) && sample_tick) begin
      if (tick_pend_q) overrun_d   = 1'b1;
      else             tick_pend_d = 1'b1;
    end
  end

  // State register; reset abandons any sweep and clears all tables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      steal_q     <= '0;
      tick_pend_q <= 1'b0;
      overrun_q   <= 1'b0;
      key_q       <= '0;
      vel_q       <= '0;
      nen_q       <= '0;
      ev_on_q     <= 1'b0;
      ev_key_q    <= '0;
      ev_vel_q    <= '0;
      cn_q        <= '0;
      velo_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      steal_q     <= steal_d;
      tick_pend_q <= tick_pend_d;
      overrun_q   <= overrun_d;
      key_q       <= key_d;
      vel_q       <= vel_d;
      nen_q       <= nen_d;
      ev_on_q     <= ev_on_d;
      ev_key_q    <= ev_key_d;
      ev_vel_q    <= ev_vel_d;
      cn_q        <= cn_d;
      velo_q      <= velo_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// tb_voice_scheduler: scoreboard bench. Each sweep pushes the expected
// {curr_note, velocity} per slot from a voice-table model; a monitor pops
// one entry per active slot.
module tb_voice_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_tick, ev_valid, ev_on;
  logic        ev_ready, sweep_done, tick_overrun;
  logic [6:0]  ev_key;
  logic [31:0] ev_velocity, velocity;
  logic [15:0] curr_note, note_enable, acc_en;

  int errs = 0;
  int checks = 0;

  logic [47:0] q[$];
  logic [6:0]  m_key[16];
  logic [31:0] m_vel[16];
  logic [15:0] m_en;
  int          m_steal;

  voice_scheduler dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
    .ev_key(ev_key), .ev_velocity(ev_velocity),
    .curr_note(curr_note), .note_enable(note_enable), .acc_en(acc_en),
    .velocity(velocity), .sweep_done(sweep_done), .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_key[i] = '0;
      m_vel[i] = '0;
    end
    m_en = '0;
    m_steal = 0;
  endtask

  task automatic model_apply(input logic on, input logic [6:0] key, input logic [31:0] vel);
    int hit;
    hit = -1;
    if (on) begin
      for (int i = 0; i < 16; i++)
        if (hit < 0 && m_en[i] && m_key[i] == key) hit = i;
      if (hit >= 0) begin
        m_vel[hit] = vel;
      end else begin
        for (int i = 0; i < 16; i++)
          if (hit < 0 && !m_en[i]) hit = i;
        if (hit < 0) begin
          hit = m_steal;
          m_steal = (m_steal + 1) % 16;
        end
        m_key[hit] = key;
        m_vel[hit] = vel;
        m_en[hit]  = 1'b1;
      end
    end else begin
      for (int i = 0; i < 16; i++)
        if (m_en[i] && m_key[i] == key) m_en[i] = 1'b0;
    end
  endtask

  task automatic push_sweep();
    logic [15:0] oh;
    for (int i = 0; i < 16; i++) begin
      oh = 16'd1 << i;
      q.push_back({oh, m_vel[i]});
    end
  endtask

  // One scoreboard pop per active slot.
  always @(negedge clk) begin
    logic [47:0] e;
    if (!rst) begin
      if (curr_note != 16'h0) begin
        chk("acc_eq_cn", acc_en, curr_note);
        if (q.size() == 0) chk("extra_slot", curr_note, 16'h0);
        else begin
          e = q.pop_front();
          chk("slot", {curr_note, velocity}, e);
        end
      end else if ((acc_en != 16'h0) || (velocity != 32'h0)) begin
        chk("idle_out", {acc_en, velocity}, 48'h0);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rdy", ev_ready, 1'b0);
    chk("rst_nen", note_enable, 16'h0);
    chk("rst_ovr", tick_overrun, 1'b0);
    q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Caller is at a negedge with the DUT idle and nothing pending.
  task automatic run_sweep();
    int n;
    push_sweep();
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!sweep_done && n < 40);
    chk("done_lat", n, 17);
    chk("q_empty", q.size(), 0);
    chk("sweep_nen", note_enable, m_en);
    if (n >= 40) q.delete();
  endtask

  task automatic send_ev(input logic on, input logic [6:0] key, input logic [31:0] vel);
    int n;
    ev_valid = 1'b1; ev_on = on; ev_key = key; ev_velocity = vel;
    n = 0;
    @(negedge clk);
    while (!ev_ready && n < 100) begin @(negedge clk); n++; end
    chk("ev_accept", n < 100, 1'b1);
    @(posedge clk); #1;
    ev_valid = 1'b0;
    model_apply(on, key, vel);
    @(negedge clk);
    chk("ev_busy", ev_ready, 1'b0);
    @(negedge clk);
    chk("ev_nen", note_enable, m_en);
    chk("ev_rdy2", ev_ready, 1'b1);
  endtask

  initial begin
    int n, d;
    rst = 1'b1; sample_tick = 1'b0; ev_valid = 1'b0; ev_on = 1'b0;
    ev_key = '0; ev_velocity = '0;
    model_reset();
    #2;
    chk("rst_cn", curr_note, 16'h0);
    chk("rst_acc", acc_en, 16'h0);
    chk("rst_vel", velocity, 32'h0);
    chk("rst_done", sweep_done, 1'b0);
    do_reset();

    // Idle sweeps, ticks 20 cycles apart.
    for (int k = 0; k < 2; k++) begin
      run_sweep();
      repeat (3) @(negedge clk);
    end

    // Allocation and note off.
    send_ev(1'b1, 7'd60, 32'h2000_0000);
    send_ev(1'b1, 7'd64, 32'h1000_0000);
    chk("two_on", note_enable, 16'h0003);
    run_sweep();
    send_ev(1'b0, 7'd60, 32'h0);
    chk("off60", note_enable, 16'h0002);

    // Fill every voice, then steal voices 0 and 1.
    do_reset();
    for (int i = 0; i < 17; i++) send_ev(1'b1, 7'(20 + i), 32'(i + 1) << 20);
    chk("full", note_enable, 16'hFFFF);
    run_sweep();
    send_ev(1'b1, 7'd50, 32'h0ABC_0000);
    run_sweep();
    send_ev(1'b0, 7'd36, 32'h0);
    chk("off_stolen", note_enable, 16'hFFFE);

    // Retrigger.
    do_reset();
    send_ev(1'b1, 7'd60, 32'h1000_0000);
    send_ev(1'b1, 7'd60, 32'h3000_0000);
    chk("retrig_nen", note_enable, 16'h0001);
    run_sweep();

    // Tick and event offered in the same cycle: sweep goes first.
    push_sweep();
    ev_valid = 1'b1; ev_on = 1'b1; ev_key = 7'd70; ev_velocity = 32'h5;
    sample_tick = 1'b1;
    #1;
    chk("rdy_tick", ev_ready, 1'b0);
    @(posedge clk); #1;
    sample_tick = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 8) chk("rdy_sweep", ev_ready, 1'b0);
    end while (!sweep_done && n < 40);
    chk("tev_lat", n, 17);
    chk("rdy_done", ev_ready, 1'b1);
    @(posedge clk); #1;
    ev_valid = 1'b0;
    model_apply(1'b1, 7'd70, 32'h5);
    @(negedge clk);
    chk("rdy_evt", ev_ready, 1'b0);
    @(negedge clk);
    chk("tev_nen", note_enable, m_en);

    // Tick during EVENT is delayed by one cycle.
    ev_valid = 1'b1; ev_on = 1'b1; ev_key = 7'd72; ev_velocity = 32'h7;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    sample_tick = 1'b1;
    model_apply(1'b1, 7'd72, 32'h7);
    push_sweep();
    @(posedge clk); #1;
    sample_tick = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (curr_note == 16'h0 && n < 10);
    chk("evt_tick_lat", n, 2);
    n = 0;
    do begin @(negedge clk); n++; end while (!sweep_done && n < 40);
    chk("evt_tick_done", n, 16);
    chk("evt_tick_nen", note_enable, 16'h0007);

    // Two extra ticks within one sweep.
    chk("ovr_pre", tick_overrun, 1'b0);
    push_sweep();
    push_sweep();
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    for (int k = 0; k < 2; k++) begin
      repeat (2) @(posedge clk);
      #1 sample_tick = 1'b1;
      @(posedge clk); #1;
      sample_tick = 1'b0;
    end
    d = 0; n = 0;
    while (d < 2 && n < 100) begin
      @(negedge clk); n++;
      if (sweep_done) d++;
    end
    chk("ovr_sweeps", d, 2);
    chk("ovr_set", tick_overrun, 1'b1);
    chk("ovr_q", q.size(), 0);
    q.delete();
    @(negedge clk);

    // Reset at slot 7.
    push_sweep();
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (curr_note != 16'h0080 && n < 30);
    chk("slot7_seen", curr_note, 16'h0080);
    #1 rst = 1'b1;
    #1;
    q.delete();
    model_reset();
    chk("mrst_cn", curr_note, 16'h0);
    chk("mrst_acc", acc_en, 16'h0);
    chk("mrst_nen", note_enable, 16'h0);
    chk("mrst_vel", velocity, 32'h0);
    chk("mrst_ovr", tick_overrun, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_sweep();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
